// File: rtl/ship_placer_pkg.sv
// ship_placer_pkg: shared states, error codes and grid constants for the ship placer.
// Defining SHIP_PLACER_ADJ_CHECK_EN makes the scan cover the ship's one-cell surround.
package ship_placer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SCAN, S_WAIT, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_BOUNDS, ERR_OVERLAP, ERR_DIM} err_t;
  localparam logic [4:0] GRID_SIZE = 5'd10;
  localparam logic [3:0] G_MAX = 4'(GRID_SIZE - 5'd1);
  localparam logic [3:0] MAX_DIM = 4'd5;
  localparam logic [4:0] EMPTY_VALUE = 5'd0;
  localparam logic [3:0] READ_LAT = 4'd1;
`ifdef SHIP_PLACER_ADJ_CHECK_EN
  localparam bit ADJ_EN = 1'b1;
`else
  localparam bit ADJ_EN = 1'b0;
`endif
endpackage

// File: rtl/ship_placer_walker.sv
// cell_walker: steps row-major through a ship's cells, or its grid-clipped surround in box mode.
module cell_walker
  import ship_placer_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load_i,
  input  logic       adv_i,
  input  logic       box_i,
  input  logic [3:0] ox_i,
  input  logic [3:0] oy_i,
  input  logic       dir_i,
  input  logic [3:0] len_i,
  output logic [3:0] x_o,
  output logic [3:0] y_o,
  output logic       last_o
);
  logic [3:0] ex, ey, x0_d, y0_d, x1_d, y1_d;
  logic [3:0] x0_q, x1_q, y1_q, x_q, y_q;
  always_comb begin
    ex = dir_i ? ox_i : ox_i + len_i - 4'd1;
    ey = dir_i ? oy_i + len_i - 4'd1 : oy_i;
    x0_d = (box_i && ox_i != 4'd0) ? ox_i - 4'd1 : ox_i;
    y0_d = (box_i && oy_i != 4'd0) ? oy_i - 4'd1 : oy_i;
    x1_d = (box_i && ex < G_MAX) ? ex + 4'd1 : ex;
    y1_d = (box_i && ey < G_MAX) ? ey + 4'd1 : ey;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (load_i) begin
      x0_q <= x0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      x_q  <= x0_d;
      y_q  <= y0_d;
    end else if (adv_i) begin
      x_q <= (x_q == x1_q) ? x0_q : x_q + 4'd1;
      y_q <= (x_q == x1_q) ? y_q + 4'd1 : y_q;
    end
  end
  assign x_o = x_q;
  assign y_o = y_q;
  assign last_o = (x_q == x1_q) && (y_q == y1_q);
endmodule

// File: rtl/ship_placer.sv
// ship_placer: validates a ship placement, scans target cells for occupancy, then writes the ship.
// SHIP_PLACER_ADJ_CHECK_EN (see package) extends the scan to neighbouring cells.
module ship_placer
  import ship_placer_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start,
  input  logic [3:0] origin_x,
  input  logic [3:0] origin_y,
  input  logic       direction,
  input  logic [3:0] dimension,
  input  logic [4:0] ship_value,
  output logic [3:0] mem_x,
  output logic [3:0] mem_y,
  output logic       mem_we,
  output logic [4:0] mem_value,
  input  logic [4:0] mem_rd_status,
  output logic       busy,
  output logic       done,
  output logic       ship_placed,
  output logic [1:0] err
);
  state_t state_q, state_d;
  err_t err_q, err_d;
  logic placed_q, placed_d;
  logic [3:0] cnt_q, cnt_d, ox_q, oy_q, dim_q;
  logic dir_q;
  logic [4:0] val_q;
  logic latch, load, adv, box, last, dim_bad, oob;
  logic [3:0] wx, wy;
  logic [4:0] end_s;
  cell_walker u_walker (
    .clk_in(clk_in), .rst_in(rst_in), .load_i(load), .adv_i(adv), .box_i(box),
    .ox_i(ox_q), .oy_i(oy_q), .dir_i(dir_q), .len_i(dim_q),
    .x_o(wx), .y_o(wy), .last_o(last)
  );
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      err_q    <= ERR_NONE;
      placed_q <= 1'b0;
      cnt_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      dim_q    <= '0;
      dir_q    <= 1'b0;
      val_q    <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      placed_q <= placed_d;
      cnt_q    <= cnt_d;
      if (latch) begin
        ox_q  <= origin_x;
        oy_q  <= origin_y;
        dim_q <= dimension;
        dir_q <= direction;
        val_q <= ship_value;
      end
    end
  end
  // End coordinate on the stepped axis is 5 bits wide so it cannot wrap back into the grid.
  assign end_s = {1'b0, dir_q ? oy_q : ox_q} + {1'b0, dim_q} - 5'd1;
  assign dim_bad = (dim_q == 4'd0) || (dim_q > MAX_DIM);
  assign oob = (end_s > {1'b0, G_MAX}) || ((dir_q ? ox_q : oy_q) > G_MAX);
  assign box = ADJ_EN && (state_q == S_CHECK);
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    placed_d = placed_q;
    cnt_d    = cnt_q;
    latch    = 1'b0;
    load     = 1'b0;
    adv      = 1'b0;
    case (state_q)
      S_IDLE: begin
        latch    = start;
        err_d    = start ? ERR_NONE : err_q;
        placed_d = start ? 1'b0 : placed_q;
        state_d  = start ? S_CHECK : S_IDLE;
      end
      S_CHECK: begin
        err_d   = dim_bad ? ERR_DIM : oob ? ERR_BOUNDS : ERR_NONE;
        load    = !(dim_bad || oob);
        state_d = (dim_bad || oob) ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == READ_LAT - 4'd1) begin
          err_d   = (mem_rd_status != EMPTY_VALUE) ? ERR_OVERLAP : ERR_NONE;
          load    = (mem_rd_status == EMPTY_VALUE) && last;
          adv     = (mem_rd_status == EMPTY_VALUE) && !last;
          state_d = (mem_rd_status != EMPTY_VALUE) ? S_DONE : last ? S_WRITE : S_SCAN;
        end
      end
      S_WRITE: begin
        adv      = 1'b1;
        placed_d = last;
        state_d  = last ? S_DONE : S_WRITE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign mem_x = (state_q inside {S_SCAN, S_WAIT, S_WRITE}) ? wx : 4'd0;
  assign mem_y = (state_q inside {S_SCAN, S_WAIT, S_WRITE}) ? wy : 4'd0;
  assign mem_we = (state_q == S_WRITE);
  assign mem_value = mem_we ? val_q : 5'd0;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign ship_placed = placed_q;
  assign err = err_q;
endmodule

// File: tb/tb_ship_placer.sv
// tb_ship_placer: scoreboard bench for ship_placer with a registered-read cell memory model.
module tb_ship_placer;
  logic clk = 1'b0, rst_in, start, direction, mem_we, busy, done, ship_placed;
  logic [3:0] origin_x, origin_y, dimension, mem_x, mem_y;
  logic [4:0] ship_value, mem_value, mem_rd_status;
  logic [1:0] err;
  logic clr, poke;
  logic [3:0] px, py;
  logic [4:0] pv;
  logic [4:0] grid [10][10];
  int total = 0, bad = 0;
  typedef struct {int x; int y; logic [4:0] v;} wr_t;
  typedef struct {logic [1:0] e; logic p; int lat;} exp_t;
  wr_t wr_q[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ship_placer dut (
    .clk_in(clk), .rst_in(rst_in), .start(start), .origin_x(origin_x), .origin_y(origin_y),
    .direction(direction), .dimension(dimension), .ship_value(ship_value),
    .mem_x(mem_x), .mem_y(mem_y), .mem_we(mem_we), .mem_value(mem_value),
    .mem_rd_status(mem_rd_status), .busy(busy), .done(done), .ship_placed(ship_placed), .err(err)
  );

  always @(posedge clk) begin
    mem_rd_status <= (mem_x < 4'd10 && mem_y < 4'd10) ? grid[mem_y][mem_x] : 5'd0;
    if (clr) begin
      for (int i = 0; i < 10; i++)
        for (int j = 0; j < 10; j++) grid[i][j] <= 5'd0;
    end else if (poke) grid[py][px] <= pv;
    else if (mem_we && mem_x < 4'd10 && mem_y < 4'd10) grid[mem_y][mem_x] <= mem_value;
  end

  // Advance one cycle and pop the write scoreboard whenever the DUT writes.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    if (mem_we === 1'b1) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got x=%0d y=%0d v=%0d, expected no write", mem_x, mem_y, mem_value);
      end else begin
        w = wr_q.pop_front();
        if (mem_x !== w.x[3:0] || mem_y !== w.y[3:0] || mem_value !== w.v) begin
          bad++;
          $display("FAIL write_cell: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                   mem_x, mem_y, mem_value, w.x, w.y, w.v);
        end
      end
    end
  endtask

  task automatic clear_grid();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic place(input int ox, input int oy, input bit d, input int dim, input logic [4:0] v,
                       input bit again);
    exp_t x, got;
    int ex, ey, x0, x1, y0, y1, n, cnt, extra;
    bit hit;
    x.lat = 2;
    if (dim == 0 || dim > 5) x.e = 2'd3;
    else begin
      ex = d ? ox : ox + dim - 1;
      ey = d ? oy + dim - 1 : oy;
      if (ex > 9 || ey > 9) x.e = 2'd1;
      else begin
        x0 = ox; x1 = ex; y0 = oy; y1 = ey;
`ifdef SHIP_PLACER_ADJ_CHECK_EN
        x0 = x0 > 0 ? x0 - 1 : 0; x1 = x1 < 9 ? x1 + 1 : 9;
        y0 = y0 > 0 ? y0 - 1 : 0; y1 = y1 < 9 ? y1 + 1 : 9;
`endif
        n = 0; hit = 1'b0;
        for (int yy = y0; yy <= y1; yy++)
          for (int xx = x0; xx <= x1; xx++)
            if (!hit) begin
              n++;
              if (grid[yy][xx] != 5'd0) hit = 1'b1;
            end
        x.e = hit ? 2'd2 : 2'd0;
        x.lat = hit ? 2 + 2 * n : 2 + 2 * n + dim;
        if (!hit) for (int k = 0; k < dim; k++) wr_q.push_back('{d ? ox : ox + k, d ? oy + k : oy, v});
      end
    end
    x.p = (x.e == 2'd0);
    exp_q.push_back(x);
    origin_x = 4'(ox); origin_y = 4'(oy); direction = d; dimension = 4'(dim); ship_value = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    origin_x = ~origin_x; origin_y = ~origin_y; direction = ~d; dimension = 4'd2; ship_value = ~v;
    cnt = 1;
    while (done !== 1'b1 && cnt < 300) begin
      start = again && cnt == 3;
      tick();
      cnt++;
    end
    start = 1'b0;
    got = exp_q.pop_front();
    total++;
    if (done !== 1'b1 || cnt != got.lat) begin
      bad++;
      $display("FAIL done_latency (%0d,%0d) D=%0d: got cycle %0d done=%b expected cycle %0d", ox, oy, dim, cnt, done, got.lat);
    end
    total++;
    if (err !== got.e || ship_placed !== got.p || busy !== 1'b1) begin
      bad++;
      $display("FAIL result (%0d,%0d) D=%0d: got err=%0d placed=%b busy=%b expected err=%0d placed=%b busy=1",
               ox, oy, dim, err, ship_placed, busy, got.e, got.p);
    end
    extra = 0;
    for (int i = 0; i < (again ? 20 : 3); i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra != 0 || wr_q.size() != 0 || err !== got.e || busy !== 1'b0) begin
      bad++;
      $display("FAIL after_done (%0d,%0d) D=%0d: got extra_done=%0d pending_writes=%0d err=%0d busy=%b expected 0,0,%0d,0",
               ox, oy, dim, extra, wr_q.size(), err, busy, got.e);
      wr_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    total++;
    if ({mem_x, mem_y, mem_we, mem_value, busy, done, ship_placed, err} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs: got x=%0d y=%0d we=%b val=%0d busy=%b done=%b placed=%b err=%0d expected all 0",
               mem_x, mem_y, mem_we, mem_value, busy, done, ship_placed, err);
    end
    rst_in = 1'b0;
    clear_grid();
  endtask

  task automatic test_place_basic();
    place(2, 3, 1'b0, 3, 5'd7, 1'b0);
    total++;
    if (grid[3][2] !== 5'd7 || grid[3][3] !== 5'd7 || grid[3][4] !== 5'd7 || grid[3][5] !== 5'd0) begin
      bad++;
      $display("FAIL grid_contents: got %0d %0d %0d %0d expected 7 7 7 0", grid[3][2], grid[3][3], grid[3][4], grid[3][5]);
    end
    place(5, 0, 1'b0, 5, 5'd3, 1'b0);
  endtask

  task automatic test_bounds();
    place(8, 0, 1'b0, 3, 5'd4, 1'b0);
    place(0, 9, 1'b1, 2, 5'd4, 1'b0);
    place(12, 1, 1'b1, 2, 5'd4, 1'b0);
  endtask

  task automatic test_dim();
    place(0, 0, 1'b0, 0, 5'd4, 1'b0);
    place(0, 0, 1'b0, 6, 5'd4, 1'b0);
    place(9, 9, 1'b1, 6, 5'd4, 1'b0);
  endtask

  task automatic test_overlap();
    clear_grid();
    px = 4'd4; py = 4'd4; pv = 5'd3; poke = 1'b1;
    tick();
    poke = 1'b0;
    place(4, 2, 1'b1, 4, 5'd6, 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_grid();
    place(0, 5, 1'b1, 4, 5'd9, 1'b1);
    place(9, 5, 1'b1, 5, 5'd2, 1'b0);
    place(0, 0, 1'b0, 2, 5'd11, 1'b0);
  endtask

  task automatic test_adjacent();
    clear_grid();
    place(5, 5, 1'b0, 1, 5'd4, 1'b0);
    place(6, 6, 1'b0, 2, 5'd8, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    int n;
    clear_grid();
    for (int k = 0; k < 5; k++) wr_q.push_back('{k, 0, 5'd1});
    origin_x = 4'd0; origin_y = 4'd0; direction = 1'b0; dimension = 4'd5; ship_value = 5'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (mem_we !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (mem_we !== 1'b1) begin
      bad++;
      $display("FAIL write_phase_reached: got mem_we=%b expected 1", mem_we);
    end
    rst_in = 1'b1;
    tick();
    total++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_write: got we=%b busy=%b done=%b expected 0 0 0", mem_we, busy, done);
    end
    rst_in = 1'b0;
    wr_q.delete();
    clear_grid();
    place(1, 1, 1'b0, 2, 5'd5, 1'b0);
  endtask

  initial begin
    rst_in = 1'b1; start = 1'b0; clr = 1'b1; poke = 1'b0; px = '0; py = '0; pv = '0;
    origin_x = '0; origin_y = '0; direction = 1'b0; dimension = '0; ship_value = '0;
    test_reset();
    test_place_basic();
    test_bounds();
    test_dim();
    test_overlap();
    test_back_to_back();
    test_adjacent();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
